// File: rtl/m_dm_access.sv
// M-stage data-memory access unit: address checks, byte lanes, req/ack bus FSM and load extension.
// Defining M_DM_TIMEOUT_EN adds a bus timeout of TIMEOUT_CYC cycles in BUSY/DRAIN.
module m_dm_access #(
  parameter logic [31:0] DM_TOP      = 32'h0000_2FFF,
  parameter logic [31:0] PERIPH_BASE = 32'h0000_7F00,
  parameter logic [31:0] PERIPH_TOP  = 32'h0000_7F1F,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_valid,
  input  logic [3:0]  M_mem_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_FW_Rdata2,
  input  logic        M_flush,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        M_stall,
  output logic [31:0] M_ld_data,
  output logic [4:0]  M_exc_code
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t      state;
  logic        is_load, is_store, misalign, in_dm, in_periph, bad, accept;
  logic        to_hit, timed_out;
  logic [3:0]  lanes, op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_sh, data_q;
  logic [4:0]  chk_code;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_load   = (M_mem_op >= OP_LW) && (M_mem_op <= OP_LBU);
  assign is_store  = (M_mem_op >= OP_SW) && (M_mem_op <= OP_SB);
  assign in_dm     = M_addr <= DM_TOP;
  assign in_periph = (M_addr >= PERIPH_BASE) && (M_addr <= PERIPH_TOP);

  always_comb begin
    misalign = 1'b0;
    lanes    = 4'b0000;
    wdata_sh = M_FW_Rdata2;
    case (M_mem_op)
      OP_LW, OP_SW: begin
        misalign = |M_addr[1:0];
        lanes    = 4'b1111;
      end
      OP_LH, OP_LHU, OP_SH: begin
        misalign = M_addr[0];
        lanes    = M_addr[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{M_FW_Rdata2[15:0]}};
      end
      OP_LB, OP_LBU, OP_SB: begin
        lanes    = 4'b0001 << M_addr[1:0];
        wdata_sh = {4{M_FW_Rdata2[7:0]}};
      end
      default: ;
    endcase
  end

  // Sub-word stores are not allowed into the peripheral window.
  assign bad = misalign || !(in_dm || in_periph) ||
               (in_periph && (M_mem_op == OP_SH || M_mem_op == OP_SB));

  assign chk_code = !M_valid          ? 5'd0 :
                    (is_load && bad)  ? 5'd4 :
                    (is_store && bad) ? 5'd5 : 5'd0;

  assign accept = (state == IDLE) && M_valid && (is_load || is_store) && !bad && !M_flush;

  assign M_stall    = accept || (state == BUSY && !M_flush);
  assign M_exc_code = (state == DONE && timed_out) ? (m_we ? 5'd5 : 5'd4) : chk_code;

`ifdef M_DM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (state == BUSY || state == DRAIN)
      to_cnt <= to_cnt + 8'd1;
    else
      to_cnt <= '0;
  end

  assign to_hit = (state == BUSY || state == DRAIN) && !bus_ack && (to_cnt == TO_LAST);
`else
  // Without the timeout BUSY and DRAIN wait for bus_ack indefinitely.
  assign to_hit = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_byteen  <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      data_q    <= '0;
      op_q      <= OP_NONE;
      lane_q    <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= BUSY;
          m_req     <= 1'b1;
          m_we      <= is_store;
          m_byteen  <= lanes;
          m_addr    <= {M_addr[31:2], 2'b00};
          m_wdata   <= wdata_sh;
          op_q      <= M_mem_op;
          lane_q    <= M_addr[1:0];
          timed_out <= 1'b0;
        end
        BUSY: begin
          if (bus_ack) begin
            m_req <= 1'b0;
            if (M_flush) begin
              state <= IDLE;
            end else begin
              state  <= DONE;
              data_q <= bus_rdata;
            end
          end else if (M_flush) begin
            state <= DRAIN;
          end else if (to_hit) begin
            m_req     <= 1'b0;
            state     <= DONE;
            timed_out <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          timed_out <= 1'b0;
        end
        DRAIN: if (bus_ack || to_hit) begin
          m_req <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_sel = data_q[{lane_q, 3'b000} +: 8];
  assign half_sel = data_q[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    M_ld_data = '0;
    if (state == DONE && !timed_out) begin
      case (op_q)
        OP_LW:   M_ld_data = data_q;
        OP_LH:   M_ld_data = {{16{half_sel[15]}}, half_sel};
        OP_LHU:  M_ld_data = {16'h0000, half_sel};
        OP_LB:   M_ld_data = {{24{byte_sel[7]}}, byte_sel};
        OP_LBU:  M_ld_data = {24'h000000, byte_sel};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_dm_access.sv
// Bench for m_dm_access: directed cases plus random accesses against a rule-based reference model.
// Timeout scenario is included when M_DM_TIMEOUT_EN is defined.
module tb_m_dm_access;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        M_valid;
  logic [3:0]  M_mem_op;
  logic [31:0] M_addr;
  logic [31:0] M_FW_Rdata2;
  logic        M_flush;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_byteen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        M_stall;
  logic [31:0] M_ld_data;
  logic [4:0]  M_exc_code;

  int n_cmp = 0;
  int n_err = 0;

  m_dm_access dut (
    .clk(clk), .reset_n(reset_n), .M_valid(M_valid), .M_mem_op(M_mem_op),
    .M_addr(M_addr), .M_FW_Rdata2(M_FW_Rdata2), .M_flush(M_flush),
    .m_req(m_req), .m_we(m_we), .m_byteen(m_byteen), .m_addr(m_addr),
    .m_wdata(m_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .M_stall(M_stall), .M_ld_data(M_ld_data), .M_exc_code(M_exc_code)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd6) return 4;
    if (op == 4'd2 || op == 4'd3 || op == 4'd7) return 2;
    if (op == 4'd4 || op == 4'd5 || op == 4'd8) return 1;
    return 0;
  endfunction

  function automatic logic [4:0] ref_exc(input logic [3:0] op, input logic [31:0] a);
    int  size;
    bit  ld, periph, ok;
    size = ref_size(op);
    if (size == 0) return 5'd0;
    ld     = (op <= 4'd5);
    periph = (a >= 32'h7F00) && (a <= 32'h7F1F);
    ok     = (a <= 32'h2FFF) || periph;
    if ((a % size) != 0 || !ok || (!ld && periph && size < 4)) return ld ? 5'd4 : 5'd5;
    return 5'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> (8 * (a % 4));
    case (op)
      4'd1:    return rd;
      4'd2:    return 32'($signed(w[15:0]));
      4'd3:    return w % 32'h1_0000;
      4'd4:    return 32'($signed(w[7:0]));
      4'd5:    return w % 32'h100;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_lanes(input logic [3:0] op, input logic [31:0] a);
    if (ref_size(op) == 4) return 4'hF;
    if (ref_size(op) == 2) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
    if (ref_size(op) == 4) return d;
    if (ref_size(op) == 2) return (d % 32'h1_0000) * 32'h0001_0001;
    return (d % 32'h100) * 32'h0101_0101;
  endfunction

  // One full access: present the instruction, ack after 'waits' extra BUSY cycles, check DONE.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int waits);
    logic [4:0] e_exc;
    bit         st;
    e_exc = ref_exc(op, a);
    st    = (op >= 4'd6 && op <= 4'd8);
    @(negedge clk);
    M_valid = 1'b1; M_mem_op = op; M_addr = a; M_FW_Rdata2 = wd; bus_ack = 1'b0; M_flush = 1'b0;
    #1;
    check_output("exc_code", 32'(M_exc_code), 32'(e_exc));
    if (ref_size(op) == 0 || e_exc != 5'd0) begin
      check_output("stall_noacc", 32'(M_stall), 32'd0);
      @(negedge clk); #1;
      check_output("req_noacc", 32'(m_req), 32'd0);
      M_valid = 1'b0;
      return;
    end
    check_output("stall_idle", 32'(M_stall), 32'd1);
    check_output("req_idle", 32'(m_req), 32'd0);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      bus_ack   = (w == waits);
      bus_rdata = (w == waits) ? rd : $urandom;
      #1;
      check_output("req_busy", 32'(m_req), 32'd1);
      check_output("stall_busy", 32'(M_stall), 32'd1);
      check_output("bus_addr", m_addr, a - (a % 4));
      check_output("bus_we", 32'(m_we), 32'(st));
      if (st) begin
        check_output("byteen", 32'(m_byteen), 32'(ref_lanes(op, a)));
        check_output("wdata", m_wdata, ref_wdata(op, wd));
      end
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    check_output("req_done", 32'(m_req), 32'd0);
    check_output("stall_done", 32'(M_stall), 32'd0);
    check_output("ld_data", M_ld_data, ref_load(op, a, rd));
    check_output("exc_done", 32'(M_exc_code), 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    int          r;
    int          busy_cyc;

    reset_n = 1'b0; M_valid = 1'b0; M_mem_op = 4'd0; M_addr = '0; M_FW_Rdata2 = '0;
    M_flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #12;
    check_output("rst_req", 32'(m_req), 32'd0);
    check_output("rst_we", 32'(m_we), 32'd0);
    check_output("rst_byteen", 32'(m_byteen), 32'd0);
    check_output("rst_addr", m_addr, 32'd0);
    check_output("rst_wdata", m_wdata, 32'd0);
    check_output("rst_ld", M_ld_data, 32'd0);
    check_output("rst_stall", 32'(M_stall), 32'd0);
    check_output("rst_exc", 32'(M_exc_code), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed accesses");
    apply_stimulus(4'd6, 32'h0000_0104, 32'hDEADBEEF, 32'h0, 0);
    apply_stimulus(4'd8, 32'h0000_0003, 32'h0000_00A5, 32'h0, 0);
    apply_stimulus(4'd4, 32'h0000_0003, 32'h0, 32'hA500_0000, 3);
    apply_stimulus(4'd5, 32'h0000_0003, 32'h0, 32'hA500_0000, 1);
    apply_stimulus(4'd3, 32'h0000_0102, 32'h0, 32'h8001_7FFE, 0);
    apply_stimulus(4'd2, 32'h0000_0102, 32'h0, 32'h8001_7FFE, 2);
    apply_stimulus(4'd7, 32'h0000_0206, 32'h1234_BEEF, 32'h0, 0);
    apply_stimulus(4'd1, 32'h0000_7F1C, 32'h0, 32'hCAFE_F00D, 0);
    apply_stimulus(4'd1, 32'h0000_0102, 32'h0, 32'h0, 0);
    apply_stimulus(4'd7, 32'h0000_7F00, 32'h0, 32'h0, 0);
    apply_stimulus(4'd6, 32'h0000_4000, 32'h0, 32'h0, 0);
    apply_stimulus(4'd1, 32'h0000_2FFC, 32'h0, 32'h0BAD_F00D, 0);
    apply_stimulus(4'd5, 32'h0000_3000, 32'h0, 32'h0, 0);

    $display("[TB] ack outside BUSY");
    @(negedge clk);
    M_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_output("stray_ack_req", 32'(m_req), 32'd0);
    check_output("stray_ack_ld", M_ld_data, 32'd0);

    $display("[TB] flush into DRAIN");
    @(negedge clk);
    M_valid = 1'b1; M_mem_op = 4'd1; M_addr = 32'h300; bus_ack = 1'b0;
    @(negedge clk); #1;
    check_output("fl_req_b1", 32'(m_req), 32'd1);
    @(negedge clk);
    M_flush = 1'b1;
    #1;
    check_output("fl_stall", 32'(M_stall), 32'd0);
    check_output("fl_req_b2", 32'(m_req), 32'd1);
    @(negedge clk);
    M_flush = 1'b0; M_valid = 1'b0;
    #1;
    check_output("dr_req1", 32'(m_req), 32'd1);
    check_output("dr_stall", 32'(M_stall), 32'd0);
    check_output("dr_ld1", M_ld_data, 32'd0);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    #1;
    check_output("dr_req2", 32'(m_req), 32'd1);
    check_output("dr_ld2", M_ld_data, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_output("dr_req_end", 32'(m_req), 32'd0);
    check_output("dr_ld_end", M_ld_data, 32'd0);

    $display("[TB] flush together with ack");
    @(negedge clk);
    M_valid = 1'b1; M_mem_op = 4'd1; M_addr = 32'h310;
    @(negedge clk);
    M_flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h2468_ACE0;
    #1;
    check_output("fa_stall", 32'(M_stall), 32'd0);
    @(negedge clk);
    M_flush = 1'b0; bus_ack = 1'b0; M_valid = 1'b0;
    #1;
    check_output("fa_req", 32'(m_req), 32'd0);
    check_output("fa_ld", M_ld_data, 32'd0);

    $display("[TB] async reset during BUSY");
    @(negedge clk);
    M_valid = 1'b1; M_mem_op = 4'd1; M_addr = 32'h200;
    @(negedge clk); #1;
    check_output("ar_req_before", 32'(m_req), 32'd1);
    #2;
    reset_n = 1'b0; M_valid = 1'b0;
    #1;
    check_output("ar_req", 32'(m_req), 32'd0);
    check_output("ar_stall", 32'(M_stall), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef M_DM_TIMEOUT_EN
    $display("[TB] bus timeout");
    @(negedge clk);
    M_valid = 1'b1; M_mem_op = 4'd1; M_addr = 32'h400; bus_ack = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (!m_req) break;
      busy_cyc++;
    end
    check_output("to_cycles", 32'(busy_cyc), 32'd255);
    check_output("to_exc", 32'(M_exc_code), 32'd4);
    check_output("to_ld", M_ld_data, 32'd0);
    check_output("to_stall", 32'(M_stall), 32'd0);
    @(negedge clk);
    M_valid = 1'b0;
`else
    busy_cyc = 0;
`endif

    $display("[TB] random accesses");
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 19);
      op = (r < 16) ? 4'(r % 8 + 1) : ((r == 16) ? 4'd0 : 4'(r - 8));
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom_range(0, 32'h2FFF);
        2:       a = 32'h7F00 + $urandom_range(0, 31);
        default: a = 32'h3000 + $urandom_range(0, 32'h5000);
      endcase
      apply_stimulus(op, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    @(negedge clk);
    M_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
